// File: rtl/n64_poll_engine_if.sv
// n64_poll_engine_if: request/response and single-wire line bundle for the
// N64 controller poll engine.
//   start, cmd     : one-cycle transaction request and command byte
//   pin_in         : raw level of the shared single-wire line
//   pin_drive_low  : 1 = engine pulls the line low, 0 = released
//   busy, done     : transaction in progress / one-cycle completion pulse
//   rx_data        : 32-bit controller response, first received bit in [31]
//   timeout        : last transaction ended without a controller reply
// master = requester/line side, slave = engine.
interface n64_poll_engine_if;
    logic        start;
    logic [7:0]  cmd;
    logic        pin_in;
    logic        pin_drive_low;
    logic        busy;
    logic        done;
    logic [31:0] rx_data;
    logic        timeout;

    modport master (
        output start, cmd, pin_in,
        input  pin_drive_low, busy, done, rx_data, timeout
    );

    modport slave (
        input  start, cmd, pin_in,
        output pin_drive_low, busy, done, rx_data, timeout
    );
endinterface

// File: rtl/n64_poll_engine.sv
// n64_poll_engine: sends one command byte on the N64 single-wire bus and
// collects the 32-bit controller reply, with a reply timeout.
// Ports:
//   PCLK   : single clock
//   PRESET : synchronous active-high reset
//   bus    : n64_poll_engine_if.slave (start/cmd in, line in/out,
//            busy/done/rx_data/timeout out)
// Parameters:
//   US_CYCLES  : PCLK cycles per microsecond
//   TIMEOUT_US : maximum wait for a controller falling edge, in microseconds
// Build option:
//   N64_RX_GLITCH_FILTER_EN : adds a 3-sample majority filter after the
//   synchronizer (2 extra cycles of latency on the receive path).
module n64_poll_engine #(
    parameter int unsigned US_CYCLES  = 100,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic             PCLK,
    input  logic             PRESET,
    n64_poll_engine_if.slave bus
);

    localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * US_CYCLES;
    localparam int unsigned BIT_CYC     = 4 * US_CYCLES;
    localparam int unsigned CNT_MAX     = (TIMEOUT_CYC > BIT_CYC) ? TIMEOUT_CYC : BIT_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_BIT,
        TX_STOP,
        RX_WAIT,
        RX_BIT,
        RX_END,
        DONE
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       bit_cnt_q;
    logic [7:0]       cmd_q;
    logic [31:0]      shift_q;
    logic [31:0]      rx_data_q;
    logic             pin_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             line_prev_q;

    logic             line_c;
    logic             fall_c;
    logic             tx_bit_c;
    logic [CNT_W-1:0] low_last_c;

`ifdef N64_RX_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;
    logic filt_q;

    // Registered majority of three consecutive samples: a single-cycle
    // glitch never wins the vote.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
        end
    end

    assign line_c = filt_q;
`else
    assign line_c = sync2_q;
`endif

    assign fall_c     = line_prev_q & ~line_c;
    // Command is sent MSB first, so bit counter k selects cmd[7-k].
    assign tx_bit_c   = cmd_q[~bit_cnt_q[2:0]];
    // Last count value of the low phase: 1 us for a '1', 3 us for a '0'.
    assign low_last_c = tx_bit_c ? CNT_W'(US_CYCLES - 1) : CNT_W'(3 * US_CYCLES - 1);

    // Synchronizer, edge history and transaction state machine.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            pin_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            line_prev_q <= 1'b0;
        end else begin
            sync1_q     <= bus.pin_in;
            sync2_q     <= sync1_q;
            line_prev_q <= line_c;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cmd_q     <= bus.cmd;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        timeout_q <= 1'b0;
                        pin_q     <= 1'b1;
                        state_q   <= TX_BIT;
                    end
                end

                TX_BIT: begin
                    if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                        cnt_q <= '0;
                        pin_q <= 1'b1;
                        if (bit_cnt_q == 5'd7) begin
                            state_q <= TX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        pin_q <= (cnt_q < low_last_c);
                    end
                end

                TX_STOP: begin
                    if (cnt_q == CNT_W'(US_CYCLES - 1)) begin
                        pin_q     <= 1'b0;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= RX_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                RX_WAIT: begin
                    if (fall_c) begin
                        cnt_q   <= '0;
                        state_q <= RX_BIT;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // The edge reached line_c one cycle before RX_BIT entry, so
                // count 2*US-2 lands the sample 2 us after the edge.
                RX_BIT: begin
                    if (cnt_q == CNT_W'(2 * US_CYCLES - 2)) begin
                        shift_q <= {shift_q[30:0], line_c};
                        cnt_q   <= '0;
                        if (bit_cnt_q == 5'd31) begin
                            state_q <= RX_END;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            state_q   <= RX_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                RX_END: begin
                    if (line_c) begin
                        rx_data_q <= shift_q;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pin_drive_low = pin_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.timeout       = timeout_q;

endmodule

// File: doc/n64_poll_engine.md
N64_POLL_ENGINE -- requirements
Module: n64_poll_engine

Interface
REQ-001 SHALL have parameter US_CYCLES, default 100, PCLK cycles per microsecond.
REQ-002 SHALL have parameter TIMEOUT_US, default 200, maximum wait in microseconds for a controller falling edge.
REQ-003 SHALL have port PCLK  input  1  single clock (FAB_CLK domain).
REQ-004 SHALL have port PRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transaction.
REQ-006 SHALL have port cmd  input  8  command byte, sent MSB first (0x01 = poll).
REQ-007 SHALL have port pin_in  input  1  raw level of the fab_pin single-wire line.
REQ-008 SHALL have port pin_drive_low  output  1  1 = pull line low; 0 = release (wrapper tristates fab_pin).
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port rx_data  output  32  controller response, first received bit in [31].
REQ-012 SHALL have port timeout  output  1  last transaction ended by timeout; valid when done pulses.

Function
REQ-013 SHALL pass pin_in through a 2-flop synchronizer before any use.
REQ-014 SHALL use states IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_END, DONE.
REQ-015 SHALL leave IDLE when start=1: latch cmd, set busy=1 on the next edge, enter TX_BIT, clear the bit counter and the timeout flag.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL make each TX bit 4*US_CYCLES cycles: bit 0 = low 3*US_CYCLES then released 1*US_CYCLES; bit 1 = low 1*US_CYCLES then released 3*US_CYCLES.
REQ-018 SHALL, after 8 bits, enter TX_STOP: drive low 1*US_CYCLES, then release and enter RX_WAIT.
REQ-019 SHALL, in RX_WAIT, detect a synchronized falling edge, enter RX_BIT, and sample the line exactly 2*US_CYCLES cycles after the edge.
REQ-020 SHALL shift each sampled bit into a shift register; after the sample, return to RX_WAIT until 32 bits are collected.
REQ-021 SHALL, after bit 32, enter RX_END, wait for the synchronized line to be high (controller stop bit done), then copy the shift register to rx_data and enter DONE.
REQ-022 SHALL, if RX_WAIT lasts TIMEOUT_US*US_CYCLES cycles without a falling edge, set timeout=1, leave rx_data unchanged, and enter DONE.
REQ-023 SHALL, in DONE, assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-024 SHALL keep pin_drive_low=0 in every state other than TX_BIT and TX_STOP.
REQ-025 SHALL size timing counters to hold TIMEOUT_US*US_CYCLES without wrap.
REQ-026 SHALL accept start in the cycle immediately after done.

Reset
REQ-027 SHALL, when PRESET=1 at a PCLK edge, force state IDLE, pin_drive_low=0, busy=0, done=0, timeout=0, rx_data=0, and clear all counters, the shift register and the synchronizer.
REQ-028 SHALL, on reset mid-transaction, release the line on that edge and produce no done pulse.

Configuration
REQ-029 SHALL, with macro N64_RX_GLITCH_FILTER_EN defined, pass the synchronized line through a 3-sample majority filter, adding 2 cycles latency to edge detection and sampling; the filtered level sets the REQ-019 timing.
REQ-030 SHALL, without N64_RX_GLITCH_FILTER_EN, use the synchronized line directly.

Verification (US_CYCLES=4, TIMEOUT_US=10)
REQ-031 SHALL cover: start with cmd=0x01 -> pin_drive_low low/release pattern 12/4 x7, then 4/12, then stop low 4; busy=1 throughout.
REQ-032 SHALL cover: controller model replies 0x8000_00FF after the stop bit -> one done pulse, rx_data=0x8000_00FF, timeout=0.
REQ-033 SHALL cover: no reply -> done 40 cycles after RX_WAIT entry, timeout=1, rx_data keeps the previous value.
REQ-034 SHALL cover: start pulsed during TX of bit 3 -> ignored; exactly one done.
REQ-035 SHALL cover: PRESET asserted during RX bit 10 -> next edge pin_drive_low=0, busy=0, rx_data=0, no done; a new start then completes normally.
REQ-036 SHALL cover: with N64_RX_GLITCH_FILTER_EN, 1-cycle low glitch on the line in RX_WAIT -> no bit captured; the same glitch without the macro -> captured as a falling edge.
